// File: rtl/spi_master_shifter.sv
// spi_master_shifter: SPI mode-0 master byte shifter (CPOL=0, MSB first).
// A one-entry holding register feeds the shifter. ssn stays low from byte to byte until a
// byte flagged tx_last has gone out.
// A byte occupies 16 half-periods of CLK_DIV cycles each. The low half that follows fall 8
// counts as part of the byte, so a continuous burst has no gap between bytes, and CS_HOLD
// starts counting once that trailing half-period has elapsed.
// Optional feature: define SPI_MASTER_LOOPBACK_EN to add i_loopback. While i_loopback is 1,
// the receive shifter samples the internal mosi instead of i_miso.
module spi_master_shifter #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_vld,
    output logic       o_tx_rdy,
    input  logic [7:0] i_tx_dat,
    input  logic       i_tx_last,
    output logic       o_rx_vld,
    output logic [7:0] o_rx_dat,
    output logic       o_busy,
    output logic       o_ssn,
    output logic       o_sck,
    output logic       o_mosi,
    input  logic       i_miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic       i_loopback
`endif
);

    // state  | meaning
    // IDLE   | ssn high, waiting for the holding register to fill
    // SETUP  | ssn low, CS_SETUP cycles before the first sck rise
    // XFER   | shifting a byte, 16 half-periods of CLK_DIV cycles
    // WAIT   | underrun between bytes: ssn low, sck low, mosi keeps bit0
    // HOLD   | CS_HOLD cycles after the last byte, then ssn rises
    // GAP    | ssn high for the minimum inter-transaction time
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WAIT, S_HOLD, S_GAP} state_t;

    localparam int CW = 16;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [3:0]      r_hp, w_hp;
    logic [7:0]      r_tx_sh, w_tx_sh;
    logic            r_last, w_last;
    logic [7:0]      r_rx_sh, w_rx_sh;
    logic [7:0]      r_rx_dat, w_rx_dat;
    logic            r_rx_vld, w_rx_vld;
    logic            r_ssn, w_ssn;
    logic            r_sck, w_sck;
    logic            r_mosi, w_mosi;
    logic            r_hold_full;
    logic [7:0]      r_hold_dat;
    logic            r_hold_last;
    logic            w_take;
    logic            w_cnt_zero;
    logic            w_miso_in;
    logic [7:0]      w_rx_next;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_miso_in = i_loopback ? r_mosi : i_miso;
`else
    assign w_miso_in = i_miso;
`endif

    assign w_cnt_zero = (r_cnt == '0);
    assign w_rx_next  = {r_rx_sh[6:0], w_miso_in};
    assign o_tx_rdy   = ~r_hold_full;
    assign o_busy     = (r_state != S_IDLE);
    assign o_ssn      = r_ssn;
    assign o_sck      = r_sck;
    assign o_mosi     = r_mosi;
    assign o_rx_vld   = r_rx_vld;
    assign o_rx_dat   = r_rx_dat;

    // Next-state and output logic. Whenever a byte is taken from the holding register,
    // mosi is preloaded with bit7 in the same cycle.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_hp     = r_hp;
        w_tx_sh  = r_tx_sh;
        w_last   = r_last;
        w_rx_sh  = r_rx_sh;
        w_rx_dat = r_rx_dat;
        w_rx_vld = 1'b0;
        w_ssn    = r_ssn;
        w_sck    = r_sck;
        w_mosi   = r_mosi;
        w_take   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_full) begin
                    w_take  = 1'b1;
                    w_state = S_SETUP;
                    w_cnt   = CW'(CS_SETUP - 1);
                    w_ssn   = 1'b0;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state = S_XFER;
                    w_sck   = 1'b1;
                    w_hp    = 4'd0;
                    w_cnt   = CW'(CLK_DIV - 1);
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_XFER: begin
                if (!w_cnt_zero) begin
                    w_cnt = r_cnt - 1'b1;
                end else begin
                    w_cnt = CW'(CLK_DIV - 1);
                    if (r_hp == 4'd15) begin
                        // End of the trailing low half of the byte.
                        w_hp = 4'd0;
                        if (r_last) begin
                            w_state = S_HOLD;
                            w_cnt   = CW'(CS_HOLD - 1);
                        end else if (r_hold_full) begin
                            w_take = 1'b1;
                            w_sck  = 1'b1;
                        end else begin
                            w_state = S_WAIT;
                        end
                    end else begin
                        w_hp  = r_hp + 4'd1;
                        w_sck = ~r_sck;
                        if (r_sck) begin
                            w_rx_sh = w_rx_next;
                            if (r_hp == 4'd14) begin
                                w_rx_dat = w_rx_next;
                                w_rx_vld = 1'b1;
                            end
                        end else begin
                            w_mosi  = r_tx_sh[6];
                            w_tx_sh = {r_tx_sh[6:0], 1'b0};
                        end
                    end
                end
            end
            S_WAIT: begin
                if (r_hold_full) begin
                    w_take  = 1'b1;
                    w_state = S_XFER;
                    w_sck   = 1'b1;
                    w_hp    = 4'd0;
                    w_cnt   = CW'(CLK_DIV - 1);
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_ssn = 1'b1;
                    // The cycle that ssn rises counts toward CS_IDLE.
                    if (CS_IDLE <= 1) begin
                        w_state = S_IDLE;
                    end else begin
                        w_state = S_GAP;
                        w_cnt   = CW'(CS_IDLE - 2);
                    end
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
        if (w_take) begin
            w_tx_sh = r_hold_dat;
            w_last  = r_hold_last;
            w_mosi  = r_hold_dat[7];
        end
    end

    // State and registered SPI outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hp     <= 4'd0;
            r_tx_sh  <= 8'h00;
            r_last   <= 1'b0;
            r_rx_sh  <= 8'h00;
            r_rx_dat <= 8'h00;
            r_rx_vld <= 1'b0;
            r_ssn    <= 1'b1;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_hp     <= w_hp;
            r_tx_sh  <= w_tx_sh;
            r_last   <= w_last;
            r_rx_sh  <= w_rx_sh;
            r_rx_dat <= w_rx_dat;
            r_rx_vld <= w_rx_vld;
            r_ssn    <= w_ssn;
            r_sck    <= w_sck;
            r_mosi   <= w_mosi;
        end
    end

    // Holding register. Loading and emptying never happen in the same cycle, because a load
    // needs it empty and a take needs it full.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_full <= 1'b0;
            r_hold_dat  <= 8'h00;
            r_hold_last <= 1'b0;
        end else if (w_take) begin
            r_hold_full <= 1'b0;
        end else if (i_tx_vld && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold_dat  <= i_tx_dat;
            r_hold_last <= i_tx_last;
        end
    end

endmodule
